timer_ctrl: RTL and testbench
=============================

# timer_ctrl

Programmable interval timer controller that sequences a cascade of 4-bit synchronous nibble counters. It loads a preset, enables counting, detects terminal count, and then either stops (one-shot) or reloads (periodic). It sits between software-visible control strobes and the counter datapath, and raises a sticky interrupt on each expiry.

## Interface

Parameters:
- NIBBLES, default 2: number of cascaded 4-bit counter stages. Count width W = 4*NIBBLES.

Ports:
- CLK  input  1  clock; all state changes occur on the rising edge.
- CLR_n  input  1  asynchronous active-low reset.
- START  input  1  request to start; honoured only in IDLE.
- STOP  input  1  abort; honoured in any state.
- HOLD  input  1  pause; freezes Q while in RUN.
- MODE  input  1  0 = one-shot, 1 = periodic; sampled in EXPIRE.
- PRESET  input  W  start value; sampled in LOAD.
- IRQ_ACK  input  1  clears IRQ.
- Q  output  W  current count.
- BUSY  output  1  high in LOAD, RUN and EXPIRE.
- DONE  output  1  one-cycle pulse, high exactly in EXPIRE.
- IRQ  output  1  sticky expiry flag.

## Operation

- FSM states: IDLE, LOAD, RUN, EXPIRE. All outputs are registered or Moore-decoded; no input reaches any output combinationally.
- **IDLE**
  - START=1 and STOP=0 → LOAD.
  - START and STOP together → stay IDLE (STOP wins).
- **LOAD**
  - Q <= PRESET, then → RUN.
  - STOP → IDLE with Q unchanged.
- **RUN**
  - STOP → IDLE, Q held, no DONE.
  - Otherwise, HOLD=1 → Q held, state held.
  - Otherwise, Q < all-ones → Q <= Q+1.
  - Otherwise, Q == all-ones → EXPIRE, Q held at all-ones.
- **EXPIRE**
  - DONE=1 and IRQ is set.
  - STOP → IDLE (this DONE cycle is still emitted).
  - MODE=1 → LOAD.
  - MODE=0 → IDLE.
- **Ignored inputs:** START outside IDLE has no effect. HOLD outside RUN has no effect.
- **Cascade increment:** nibble k increments when the FSM count enable is high and all nibbles below k equal 4'hF. Nibble 0 increments on the count enable alone. Nibbles wrap from F to 0.
- **IRQ:**
  - Set on any edge where the state is EXPIRE.
  - Cleared by IRQ_ACK when not being set on the same edge. Set wins over ack.
- **PRESET edge cases:**
  - PRESET = all-ones: one RUN cycle, then EXPIRE.
  - Changes to PRESET during RUN take effect at the next LOAD.
- **Reset (CLR_n=0, asynchronous):** state=IDLE, Q=0, BUSY=0, DONE=0, IRQ=0. Reset mid-count abandons the count immediately, with no DONE. Reset deassertion takes effect synchronously at the next edge.

## Timing

- START sampled in IDLE → BUSY high the next cycle, with LOAD occupying that cycle.
- Q = PRESET one cycle after LOAD.
- RUN lasts (2^W − PRESET) cycles, excluding HOLD cycles.
- DONE occurs 1 + (2^W − PRESET) cycles after LOAD is entered.
- Periodic period = 2^W − PRESET + 2 cycles (LOAD + RUN + EXPIRE), plus HOLD cycles.
- One-shot: BUSY falls the cycle after DONE.
- STOP latency: 1 edge to IDLE from any state.

## Structure

- Shared header timer_ctrl_defs.vh holds:
  - state encodings (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, EXPIRE=2'd3);
  - mode constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
- Sub-module nibble_cnt (one per stage, generated NIBBLES times):
  - inputs: CLK, CLR_n, ld, d[3:0], en, cin;
  - outputs: q[3:0], tc (q==F), cout = cin & tc;
  - asynchronous active-low clear; ld has priority over count.
- timer_ctrl contains the FSM, the IRQ flop and the carry chain (cin of stage 0 = count enable).

## Test plan

1. **Reset:** CLR_n low mid-RUN (Q=8'h42) → Q=0, BUSY=0, IRQ=0 asynchronously, before the next edge; no DONE.
2. **One-shot:** W=8, PRESET=8'hFD, MODE=0, START pulse.
   - Q: FD, FE, FF, then FF held in EXPIRE.
   - DONE exactly once, 4 cycles after LOAD is entered.
   - IRQ=1; BUSY=0 the cycle after DONE.
3. **Periodic:** PRESET=8'hFE, MODE=1 → DONE every 4 cycles for ≥3 periods. Changing PRESET to 8'hFC mid-RUN → following period is 6 cycles.
4. **Cascade carry:** PRESET=8'h0E → Q steps 0E, 0F, 10 (upper nibble increments only on lower-nibble F). HOLD for 3 cycles at Q=8'h0F → Q stays 0F, DONE delayed by 3 cycles.
5. **Simultaneous events:**
   - START+STOP in IDLE → stays IDLE.
   - STOP in EXPIRE with MODE=1 → DONE still emitted, then IDLE.
   - IRQ_ACK in EXPIRE → IRQ stays 1.
   - IRQ_ACK the next cycle → IRQ=0.
6. **Edge preset:** PRESET=8'hFF → LOAD, one RUN cycle, EXPIRE; START while BUSY is ignored; NIBBLES=1 with PRESET=4'hE → DONE 3 cycles after LOAD is entered.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared FSM encodings and mode constants for the interval timer.
// No logic of its own; one helper decodes the busy states.
// No flow control.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_EXPIRE = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Every state except IDLE counts as busy.
  function automatic logic state_busy(input state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/timer_ctrl_nibble_cnt.sv
// One 4-bit stage of the cascaded counter: parallel load or carry-gated increment.
// Latency: q updates on the edge after ld or en&cin; tc/cout are combinational.
// No backpressure; ld has priority over counting.
//
// Ports:
//   CLK, CLR_n : clock, async active-low clear (q -> 0)
//   ld, d      : synchronous load of d
//   en, cin    : increment when both high (cin is the carry from lower stages)
//   q          : stage value
//   tc         : q == 4'hF
//   cout       : cin & tc, carry into the next stage
module nibble_cnt (
  input  logic       CLK,
  input  logic       CLR_n,
  input  logic       ld,
  input  logic [3:0] d,
  input  logic       en,
  input  logic       cin,
  output logic [3:0] q,
  output logic       tc,
  output logic       cout
);

  logic [3:0] r_q;

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      r_q <= 4'h0;
    end else if (ld) begin
      r_q <= d;
    end else if (en && cin) begin
      r_q <= r_q + 4'h1;  // F wraps to 0
    end
  end

  assign q    = r_q;
  assign tc   = (r_q == 4'hF);
  assign cout = cin & tc;

endmodule

// File: rtl/timer_ctrl.sv
// Programmable interval timer: load preset, count up to all-ones, expire, stop or reload.
// Latency: START -> LOAD next cycle; DONE 1 + (2^W - PRESET) cycles after LOAD, plus HOLD cycles.
// No backpressure; STOP aborts from any state in one edge, HOLD freezes the count in RUN.
//
// Ports:
//   CLK, CLR_n : clock, async active-low reset
//   START      : start request, only acted on in IDLE
//   STOP       : abort, wins over everything else
//   HOLD       : pause counting in RUN
//   MODE       : 0 one-shot, 1 periodic (sampled in EXPIRE)
//   PRESET     : start value, sampled in LOAD
//   IRQ_ACK    : clears IRQ unless it is being set on the same edge
//   Q          : current count
//   BUSY       : high in LOAD, RUN, EXPIRE
//   DONE       : high exactly in EXPIRE
//   IRQ        : sticky expiry flag
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                 CLK,
  input  logic                 CLR_n,
  input  logic                 START,
  input  logic                 STOP,
  input  logic                 HOLD,
  input  logic                 MODE,
  input  logic [4*NIBBLES-1:0] PRESET,
  input  logic                 IRQ_ACK,
  output logic [4*NIBBLES-1:0] Q,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 IRQ
);

  state_t r_state;
  state_t w_state_nxt;

  logic                 w_busy;
  logic                 w_done;
  logic                 w_ld;
  logic                 w_cnt_en;
  logic                 w_all_ones;
  logic [4*NIBBLES-1:0] w_q;
  logic [NIBBLES-1:0]   w_tc;
  logic [NIBBLES:0]     w_carry;
  logic                 r_irq;

  // ---------------- state register ----------------
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (START && !STOP) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_state_nxt = STOP ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (STOP)            w_state_nxt = ST_IDLE;
        else if (HOLD)       w_state_nxt = ST_RUN;
        else if (w_all_ones) w_state_nxt = ST_EXPIRE;
      end
      ST_EXPIRE: begin
        if (STOP)                       w_state_nxt = ST_IDLE;
        else if (MODE == MODE_PERIODIC) w_state_nxt = ST_LOAD;
        else                            w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- output / datapath control decode ----------------
  // BUSY and DONE depend on state only. Load and count enable are internal
  // controls feeding the counter flops. The count enable drops at all-ones
  // so Q holds FF..F through the EXPIRE cycle instead of wrapping.
  always_comb begin
    w_busy   = state_busy(r_state);
    w_done   = (r_state == ST_EXPIRE);
    w_ld     = (r_state == ST_LOAD) && !STOP;
    w_cnt_en = (r_state == ST_RUN) && !STOP && !HOLD && !w_all_ones;
  end

  // ---------------- counter cascade ----------------
  assign w_carry[0] = w_cnt_en;

  for (genvar k = 0; k < NIBBLES; k++) begin : g_nib
    nibble_cnt u_nib (
      .CLK   (CLK),
      .CLR_n (CLR_n),
      .ld    (w_ld),
      .d     (PRESET[4*k +: 4]),
      .en    (w_cnt_en),
      .cin   (w_carry[k]),
      .q     (w_q[4*k +: 4]),
      .tc    (w_tc[k]),
      .cout  (w_carry[k+1])
    );
  end

  assign w_all_ones = &w_tc;

  // Counting stops at all-ones, so the top stage never carries out.
  a_no_wrap : assert property (@(posedge CLK) disable iff (!CLR_n) !w_carry[NIBBLES]);

  // ---------------- sticky interrupt ----------------
  // Set on every edge spent in EXPIRE; a same-edge ack loses.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      r_irq <= 1'b0;
    end else if (r_state == ST_EXPIRE) begin
      r_irq <= 1'b1;
    end else if (IRQ_ACK) begin
      r_irq <= 1'b0;
    end
  end

  assign Q    = w_q;
  assign BUSY = w_busy;
  assign DONE = w_done;
  assign IRQ  = r_irq;

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       start, stop, hold, mode, ack;
  logic [7:0] preset;
  logic [7:0] q;
  logic       busy, done, irq;

  logic       start1;
  logic [3:0] preset1;
  logic [3:0] q1;
  logic       busy1, done1, irq1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.NIBBLES(2)) u_dut (
    .CLK(clk), .CLR_n(clr_n), .START(start), .STOP(stop), .HOLD(hold),
    .MODE(mode), .PRESET(preset), .IRQ_ACK(ack),
    .Q(q), .BUSY(busy), .DONE(done), .IRQ(irq)
  );

  timer_ctrl #(.NIBBLES(1)) u_dut1 (
    .CLK(clk), .CLR_n(clr_n), .START(start1), .STOP(1'b0), .HOLD(1'b0),
    .MODE(1'b0), .PRESET(preset1), .IRQ_ACK(1'b0),
    .Q(q1), .BUSY(busy1), .DONE(done1), .IRQ(irq1)
  );

  // ctl = {start, stop, hold, ack, mode}; flags = {busy, done, irq}
  typedef struct packed {
    logic [4:0] ctl;
    logic [7:0] preset;
    logic [7:0] q;
    logic [2:0] flags;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic exp_done;

    //                ctl       preset  q      busy/done/irq
    tbl[0]  = '{5'b10000, 8'hFD, 8'h00, 3'b100};
    tbl[1]  = '{5'b00000, 8'hFD, 8'hFD, 3'b100};
    tbl[2]  = '{5'b00000, 8'hFD, 8'hFE, 3'b100};
    tbl[3]  = '{5'b00000, 8'hFD, 8'hFF, 3'b100};
    tbl[4]  = '{5'b00000, 8'hFD, 8'hFF, 3'b110};  // EXPIRE 4 cycles after LOAD
    tbl[5]  = '{5'b00000, 8'hFD, 8'hFF, 3'b001};  // one-shot: idle, irq set
    tbl[6]  = '{5'b11000, 8'hFD, 8'hFF, 3'b001};  // start+stop: stays idle
    tbl[7]  = '{5'b00010, 8'hFD, 8'hFF, 3'b000};  // ack clears irq
    tbl[8]  = '{5'b10000, 8'h10, 8'hFF, 3'b100};  // LOAD
    tbl[9]  = '{5'b01000, 8'h10, 8'hFF, 3'b000};  // stop in LOAD: Q unchanged
    tbl[10] = '{5'b10000, 8'h20, 8'hFF, 3'b100};
    tbl[11] = '{5'b00000, 8'h20, 8'h20, 3'b100};
    tbl[12] = '{5'b00000, 8'h20, 8'h21, 3'b100};
    tbl[13] = '{5'b01000, 8'h20, 8'h21, 3'b000};  // stop in RUN: Q held, no DONE
    tbl[14] = '{5'b10000, 8'hF0, 8'h21, 3'b100};
    tbl[15] = '{5'b00100, 8'hF0, 8'hF0, 3'b100};  // hold in LOAD ignored
    tbl[16] = '{5'b00100, 8'hF0, 8'hF0, 3'b100};  // hold in RUN freezes
    tbl[17] = '{5'b10000, 8'hF0, 8'hF1, 3'b100};  // start while busy ignored
    tbl[18] = '{5'b01000, 8'hF0, 8'hF1, 3'b000};

    start = 0; stop = 0; hold = 0; mode = 0; ack = 0; preset = 8'h00;
    start1 = 0; preset1 = 4'h0;

    // ---- reset ----
    clr_n = 1'b1;
    #2 clr_n = 1'b0;
    #1;
    chk("rst_q", q, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_irq", irq, 1'b0);
    tick();
    clr_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1'b0);

    // ---- table ----
    for (int i = 0; i < 19; i++) begin
      {start, stop, hold, ack, mode} = tbl[i].ctl;
      preset = tbl[i].preset;
      tick();
      chk($sformatf("row%0d_q", i), q, tbl[i].q);
      chk($sformatf("row%0d_busy", i), busy, tbl[i].flags[2]);
      chk($sformatf("row%0d_done", i), done, tbl[i].flags[1]);
      chk($sformatf("row%0d_irq", i), irq, tbl[i].flags[0]);
    end
    start = 0; stop = 0; hold = 0; ack = 0; mode = 0;

    // ---- periodic FE, then FC from the 4th period ----
    preset = 8'hFE; mode = 1'b1; start = 1'b1;
    tick();  // t=0: LOAD
    start = 1'b0;
    for (int tt = 1; tt <= 23; tt++) begin
      tick();
      exp_done = (tt == 3 || tt == 7 || tt == 11 || tt == 17 || tt == 23);
      chk($sformatf("per_done_t%0d", tt), done, exp_done);
      if (tt == 10) chk("per_q_before_reload", q, 8'hFF);
      if (tt == 13) chk("per_q_new_preset", q, 8'hFC);
      if (tt == 21) chk("per_irq_acked", irq, 1'b0);
      if (tt == 9)  preset = 8'hFC;
      if (tt == 20) ack = 1'b1;
      if (tt == 23) begin
        chk("per_irq_in_expire", irq, 1'b0);
        stop = 1'b1;
      end
    end
    tick();
    chk("expire_stop_busy", busy, 1'b0);
    chk("expire_stop_done", done, 1'b0);
    chk("ack_in_expire_irq", irq, 1'b1);
    stop = 1'b0; mode = 1'b0;
    tick();
    chk("ack_next_irq", irq, 1'b0);
    ack = 1'b0;

    // ---- cascade carry with hold ----
    preset = 8'h0E; start = 1'b1;
    tick();  // LOAD
    start = 1'b0;
    tick();
    chk("casc_q0E", q, 8'h0E);
    tick();
    chk("casc_q0F", q, 8'h0F);
    hold = 1'b1;
    tick();
    chk("casc_hold1", q, 8'h0F);
    tick();
    tick();
    chk("casc_hold3", q, 8'h0F);
    hold = 1'b0;
    tick();
    chk("casc_q10", q, 8'h10);
    t = 6;
    while (done !== 1'b1 && t < 400) begin
      tick();
      t++;
    end
    chk("casc_done_cycle", t, 246);
    tick();
    chk("casc_busy_after", busy, 1'b0);
    chk("casc_irq", irq, 1'b1);

    // ---- preset all-ones, start ignored while busy ----
    preset = 8'hFF; start = 1'b1;
    tick();  // LOAD; start stays high
    tick();
    chk("ff_run_q", q, 8'hFF);
    chk("ff_run_done", done, 1'b0);
    tick();
    chk("ff_expire_done", done, 1'b1);
    tick();
    chk("ff_idle_busy", busy, 1'b0);
    start = 1'b0;
    tick();
    chk("ff_no_restart", busy, 1'b0);

    // ---- single nibble, preset E ----
    preset1 = 4'hE; start1 = 1'b1;
    tick();  // LOAD
    start1 = 1'b0;
    t = 0;
    while (done1 !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk("nib1_done_cycle", t, 3);
    chk("nib1_q", q1, 4'hF);
    tick();
    chk("nib1_busy_after", busy1, 1'b0);

    // ---- async reset mid-count ----
    preset = 8'h40; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("mid_q42", q, 8'h42);
    chk("mid_irq_before", irq, 1'b1);
    #3 clr_n = 1'b0;
    #1;
    chk("arst_q", q, 8'h00);
    chk("arst_busy", busy, 1'b0);
    chk("arst_irq", irq, 1'b0);
    chk("arst_done", done, 1'b0);
    tick();
    clr_n = 1'b1;
    tick();
    chk("arst_after_busy", busy, 1'b0);
    chk("arst_after_done", done, 1'b0);
    chk("arst_after_q", q, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
